// File: rtl/aes_pkg.sv
// Shared types for the AES job scheduler: data widths, core opcodes and scheduler states.
package aes_pkg;

  typedef logic [127:0] aes_128;
  typedef logic [7:0]   aes_byte;

  typedef enum logic {
    OP_KEY_EXPAND = 1'b0,
    OP_ENCRYPT    = 1'b1
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_GO,
    ST_KEY_WAIT,
    ST_ENC_GO,
    ST_ENC_WAIT,
    ST_RESP
  } sched_state_e;

  // Index width that stays legal when there is only one requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    logic          found;
    int            j;
    logic [IW-1:0] jj;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!found && req_i[jj]) begin
        found       = 1'b1;
        grant_o[jj] = 1'b1;
        idx_o       = jj;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES-128 core among N_REQ requesters; skips key expansion when the key is cached.
module aes_job_scheduler
  import aes_pkg::*;
#(
  parameter int      N_REQ       = 4,
  parameter int      TIMEOUT_CYC = 256,
  parameter aes_byte RCON_INIT   = 8'h01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  aes_128 [N_REQ-1:0]   req_key_i,
  input  aes_128 [N_REQ-1:0]   req_pt_i,
  output logic [N_REQ-1:0]     rsp_valid_o,
  input  logic [N_REQ-1:0]     rsp_ready_i,
  output aes_128               rsp_ct_o,
  output logic                 rsp_err_o,
  output opcode_e              core_opcode_o,
  output logic                 core_start_o,
  output aes_128               core_key_o,
  output aes_byte              core_rcon_o,
  output aes_128               core_pt_o,
  input  logic                 core_key_ready_i,
  input  logic                 core_cipher_ready_i,
  input  logic                 core_busy_i,
  input  aes_128               core_cipher_i
);

  localparam int            IW       = idx_width(N_REQ);
  localparam int            CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  sched_state_e     state_q;
  logic [IW-1:0]    rr_ptr_q, gidx_q;
  aes_128           key_q, pt_q, key_last_q, rsp_ct_q;
  logic             key_vld_q, rsp_err_q;
  opcode_e          opcode_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [CW-1:0]    cnt_q;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_any;
  logic [IW-1:0]    rr_ptr_d;
  logic             key_hit_d;
  logic [N_REQ-1:0] onehot_d;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .valid_o (grant_any)
  );

  always_comb begin
    rr_ptr_d  = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);
    key_hit_d = key_vld_q && (req_key_i[grant_idx] == key_last_q);
    onehot_d  = '0;
    onehot_d[gidx_q] = 1'b1;
  end

  // Acceptance and start are the only combinational outputs so that each costs no extra cycle.
  assign req_ready_o   = (state_q == ST_IDLE) ? grant : '0;
  assign core_start_o  = ((state_q == ST_KEY_GO) || (state_q == ST_ENC_GO)) && !core_busy_i;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_ct_o      = rsp_ct_q;
  assign rsp_err_o     = rsp_err_q;
  assign core_opcode_o = opcode_q;
  assign core_key_o    = key_q;
  assign core_pt_o     = pt_q;
  assign core_rcon_o   = RCON_INIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      key_q       <= '0;
      pt_q        <= '0;
      key_last_q  <= '0;
      key_vld_q   <= 1'b0;
      opcode_q    <= OP_KEY_EXPAND;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_ct_q    <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (grant_any) begin
          gidx_q   <= grant_idx;
          key_q    <= req_key_i[grant_idx];
          pt_q     <= req_pt_i[grant_idx];
          rr_ptr_q <= rr_ptr_d;
          opcode_q <= key_hit_d ? OP_ENCRYPT : OP_KEY_EXPAND;
          state_q  <= key_hit_d ? ST_ENC_GO : ST_KEY_GO;
        end
        ST_KEY_GO: if (!core_busy_i) begin
          cnt_q   <= '0;
          state_q <= ST_KEY_WAIT;
        end
        ST_KEY_WAIT: begin
          if (core_key_ready_i) begin
            key_last_q <= key_q;
            key_vld_q  <= 1'b1;
            opcode_q   <= OP_ENCRYPT;
            state_q    <= ST_ENC_GO;
          end else if (cnt_q == CNT_LAST) begin
            key_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_ct_q    <= '0;
            rsp_valid_q <= onehot_d;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_ENC_GO: if (!core_busy_i) begin
          cnt_q   <= '0;
          state_q <= ST_ENC_WAIT;
        end
        ST_ENC_WAIT: begin
          if (core_cipher_ready_i) begin
            rsp_ct_q    <= core_cipher_i;
            rsp_valid_q <= onehot_d;
            state_q     <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            // A dead core may have lost the expanded key, so force a re-expand next time.
            key_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b1;
            rsp_ct_q    <= '0;
            rsp_valid_q <= onehot_d;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RESP: if (|(rsp_valid_q & rsp_ready_i)) begin
          rsp_valid_q <= '0;
          rsp_err_q   <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Scoreboard bench for aes_job_scheduler with a behavioural stand-in for the AES core.
module tb_aes_job_scheduler;
  import aes_pkg::*;

  localparam int N  = 4;
  localparam int TO = 256;
  localparam aes_128 K_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_128 P_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam aes_128 C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  aes_128 [N-1:0] req_key = '0, req_pt = '0;
  aes_128        rsp_ct, core_key, core_pt, core_cipher = '0;
  logic          rsp_err, core_start;
  logic          core_key_ready = 1'b0, core_cipher_ready = 1'b0, busy_force = 1'b0;
  opcode_e       core_opcode;
  aes_byte       core_rcon;

  typedef struct { int idx; aes_128 ct; logic err; } exp_t;
  exp_t sb[$];
  int   grant_log[$];
  int   errors = 0, checks = 0;
  int   kx_starts = 0, enc_starts = 0, cyc = 0, enc_start_cyc = 0, rsp_cyc = 0;
  int   key_lat = 3;
  bit   cipher_hang = 1'b0;

  aes_job_scheduler #(.N_REQ(N), .TIMEOUT_CYC(TO), .RCON_INIT(8'h01)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_key_i(req_key), .req_pt_i(req_pt),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_ct_o(rsp_ct), .rsp_err_o(rsp_err),
    .core_opcode_o(core_opcode), .core_start_o(core_start),
    .core_key_o(core_key), .core_rcon_o(core_rcon), .core_pt_o(core_pt),
    .core_key_ready_i(core_key_ready), .core_cipher_ready_i(core_cipher_ready),
    .core_busy_i(busy_force), .core_cipher_i(core_cipher)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Core stand-in: fixed latencies; FIPS-197 vector for the known pair, key^pt otherwise.
  initial begin
    int kcnt, ccnt;
    aes_128 lk, lp;
    kcnt = 0; ccnt = 0; lk = '0; lp = '0;
    forever begin
      @(negedge clk);
      core_key_ready    = 1'b0;
      core_cipher_ready = 1'b0;
      if (rst) begin
        kcnt = 0;
        ccnt = 0;
      end else begin
        if (kcnt > 0) begin
          kcnt--;
          if (kcnt == 0) core_key_ready = 1'b1;
        end
        if (ccnt > 0) begin
          ccnt--;
          if (ccnt == 0) begin
            core_cipher_ready = 1'b1;
            core_cipher = (lk == K_FIPS && lp == P_FIPS) ? C_FIPS : (lk ^ lp);
          end
        end
        if (core_start) begin
          if (core_opcode == OP_KEY_EXPAND) kcnt = key_lat;
          else if (!cipher_hang) begin
            ccnt = 3;
            lk = core_key;
            lp = core_pt;
          end
        end
      end
    end
  end

  // Monitor: start bookkeeping and response scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (core_start) begin
      check("start_while_busy", 128'(busy_force), 128'(0));
      if (core_opcode == OP_KEY_EXPAND) kx_starts++;
      else begin
        enc_starts++;
        enc_start_cyc = cyc;
      end
    end
    if ((rsp_valid & rsp_ready) != '0) begin
      rsp_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: rsp_valid=%b with no job outstanding, required none", rsp_valid);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", 128'(rsp_valid), 128'(1) << e.idx);
        check("rsp_ct", rsp_ct, e.ct);
        check("rsp_err", 128'(rsp_err), 128'(e.err));
        $display("rsp: req=%0d ct=%h err=%0b", e.idx, rsp_ct, rsp_err);
      end
    end
  end

  // Requester side: log each acceptance and drop valid after the accepting edge.
  initial forever begin
    logic [N-1:0] acc;
    @(negedge clk);
    acc = req_ready;
    if (acc != '0) begin
      check("req_ready_onehot", 128'($onehot(acc)), 128'(1));
      for (int i = 0; i < N; i++) if (acc[i]) grant_log.push_back(i);
      @(posedge clk);
      #1 req_valid = req_valid & ~acc;
    end
  end

  task automatic issue(input int i, input aes_128 k, input aes_128 p);
    @(posedge clk);
    #1;
    req_key[i]   = k;
    req_pt[i]    = p;
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_rsp(input int i, input aes_128 ct, input logic err);
    sb.push_back('{idx: i, ct: ct, err: err});
  endtask

  task automatic wait_done(input int budget);
    int b;
    b = budget;
    while ((sb.size() != 0 || req_valid != '0) && b > 0) begin
      @(negedge clk);
      b--;
    end
    checks++;
    if (b == 0) begin
      errors++;
      $display("FAIL wait_done: timed out with %0d responses outstanding, required 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_err", 128'(rsp_err), 128'(0));
    check("rst_rsp_ct", rsp_ct, 128'(0));
    check("rst_core_start", 128'(core_start), 128'(0));
    check("rst_core_opcode", 128'(core_opcode), 128'(OP_KEY_EXPAND));
    check("rst_core_key", core_key, 128'(0));
    check("rst_core_pt", core_pt, 128'(0));
    check("rst_core_rcon", 128'(core_rcon), 128'(8'h01));
  endtask

  task automatic clear_counts();
    kx_starts  = 0;
    enc_starts = 0;
  endtask

  initial begin
    int b, exp_order[5];
    aes_128 k3[4], c3[4];
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) k3[i] = {16{aes_byte'(8'h10 + i)}};
    c3 = '{{16{8'hB5}}, {16{8'hB4}}, {16{8'hB7}}, {16{8'hB6}}};

    repeat (2) @(posedge clk);
    do_reset();

    // Single job, key not cached.
    clear_counts();
    expect_rsp(0, C_FIPS, 1'b0);
    issue(0, K_FIPS, P_FIPS);
    wait_done(200);
    check("t1_kx_starts", 128'(kx_starts), 128'(1));
    check("t1_enc_starts", 128'(enc_starts), 128'(1));

    // Same key: key expansion skipped.
    clear_counts();
    expect_rsp(0, C_FIPS, 1'b0);
    issue(0, K_FIPS, P_FIPS);
    wait_done(200);
    check("t2_kx_starts", 128'(kx_starts), 128'(0));
    check("t2_enc_starts", 128'(enc_starts), 128'(1));

    // Busy core holds off the encrypt start.
    clear_counts();
    busy_force = 1'b1;
    expect_rsp(0, C_FIPS, 1'b0);
    b = grant_log.size();
    issue(0, K_FIPS, P_FIPS);
    for (int w = 0; w < 20 && grant_log.size() == b; w++) @(negedge clk);
    check("t5_granted", 128'(grant_log.size()), 128'(b + 1));
    repeat (10) @(negedge clk);
    check("t5_no_start_busy", 128'(enc_starts), 128'(0));
    @(posedge clk);
    #1 busy_force = 1'b0;
    @(negedge clk);
    check("t5_start_first", 128'(core_start), 128'(1));
    @(negedge clk);
    check("t5_start_width", 128'(core_start), 128'(0));
    wait_done(200);
    check("t5_enc_starts", 128'(enc_starts), 128'(1));
    check("t5_kx_starts", 128'(kx_starts), 128'(0));

    // Round-robin order from reset, then a re-raised requester waits its turn.
    do_reset();
    grant_log.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      req_key[i] = k3[i];
      req_pt[i]  = {16{8'hA5}};
      expect_rsp(i, c3[i], 1'b0);
    end
    expect_rsp(0, {16{8'h85}}, 1'b0);
    req_valid = '1;
    b = 0;
    while (grant_log.size() < 2 && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("t3_two_grants", 128'(grant_log.size() >= 2), 128'(1));
    issue(0, {16{8'h20}}, {16{8'hA5}});
    wait_done(600);
    check("t3_grant_count", 128'(grant_log.size()), 128'(5));
    for (int i = 0; i < 5; i++)
      if (i < grant_log.size()) check("t3_grant_order", 128'(grant_log[i]), 128'(exp_order[i]));

    // Encryption never completes: timeout response, then the same key is re-expanded.
    clear_counts();
    cipher_hang = 1'b1;
    expect_rsp(1, 128'(0), 1'b1);
    issue(1, {16{8'h4c}}, {16{8'h33}});
    wait_done(TO + 100);
    check("t4_timeout_latency", 128'(rsp_cyc - enc_start_cyc), 128'(TO + 1));
    cipher_hang = 1'b0;
    clear_counts();
    expect_rsp(1, {16{8'h7f}}, 1'b0);
    issue(1, {16{8'h4c}}, {16{8'h33}});
    wait_done(200);
    check("t4_reexpand", 128'(kx_starts), 128'(1));

    // Reset during key expansion drops the job without a response.
    clear_counts();
    key_lat = 40;
    issue(2, {16{8'h66}}, {16{8'h99}});
    b = 0;
    while (kx_starts == 0 && b < 20) begin
      @(negedge clk);
      b++;
    end
    check("t6_kx_started", 128'(kx_starts), 128'(1));
    repeat (2) @(negedge clk);
    do_reset();
    key_lat = 3;
    repeat (5) @(negedge clk);
    clear_counts();
    expect_rsp(2, {16{8'hFF}}, 1'b0);
    issue(2, {16{8'h66}}, {16{8'h99}});
    wait_done(200);
    check("t6_reexpand", 128'(kx_starts), 128'(1));

    repeat (5) @(negedge clk);
    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
